// File: rtl/mult_pkg.sv
// Shared definitions for the sequential-multiplier stream feeder.
//   feeder_state_t : control states of the feeder FSM
//   prod_width()   : product width for a given operand width (2*WIDTH)
//   mul_cycles()   : multiplier occupancy in cycles for a given operand width
//   PROD_WIDTH / MUL_CYCLES : the above evaluated at the default WIDTH of 4
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    BUSY   = 3'd2,
    SETTLE = 3'd3,
    HOLD   = 3'd4
  } feeder_state_t;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

  function automatic int mul_cycles(input int width);
    return 2 * width + 3;
  endfunction

  localparam int DEFAULT_WIDTH = 4;
  localparam int PROD_WIDTH    = prod_width(DEFAULT_WIDTH);
  localparam int MUL_CYCLES    = mul_cycles(DEFAULT_WIDTH);

endpackage

// File: rtl/mult_operand_fifo.sv
// Operand-pair FIFO for the multiplier feeder.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push        : write push_data (ignored when full)
//   push_data   : {multiplicand, multiplier}, 2*WIDTH bits
//   pop         : discard the head entry (ignored when empty)
//   pop_data    : head entry, valid whenever empty is low
//   full, empty : occupancy flags
module mult_operand_fifo
  import mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [prod_width(WIDTH)-1:0] push_data,
  input  logic                         pop,
  output logic [prod_width(WIDTH)-1:0] pop_data,
  output logic                         full,
  output logic                         empty
);

  localparam int DW = prod_width(WIDTH);
  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit: equal addresses with differing MSBs means full.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mult_stream_feeder.sv
// Stream wrapper around a constant-time sequential multiplier.
// Buffers operand pairs, issues one start pulse per pair, holds operands
// stable for the multiplier, captures the product after mul_done and offers
// it on an output valid/ready stream.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   in_valid/in_ready                : operand input handshake
//   in_multiplicand/in_multiplier    : operand pair, WIDTH bits each
//   mul_start                        : one-cycle start pulse to the multiplier
//   mul_multiplicand/mul_multiplier  : operands held for the running job
//   mul_done                         : productDone from the multiplier
//   mul_product                      : multiplier product register, 2*WIDTH
//   out_valid/out_ready              : result output handshake
//   out_product                      : captured product, 2*WIDTH
module mult_stream_feeder
  import mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_multiplicand,
  input  logic [WIDTH-1:0]             in_multiplier,
  output logic                         mul_start,
  output logic [WIDTH-1:0]             mul_multiplicand,
  output logic [WIDTH-1:0]             mul_multiplier,
  input  logic                         mul_done,
  input  logic [prod_width(WIDTH)-1:0] mul_product,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [prod_width(WIDTH)-1:0] out_product
);

  localparam int PW = prod_width(WIDTH);

  feeder_state_t state;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [PW-1:0] fifo_head;
  logic          slot_free;
  logic          capture;

  assign in_ready  = !fifo_full;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  // The result slot can take a new product if it is empty or being drained now.
  assign slot_free = !out_valid || out_ready;
  assign capture   = ((state == SETTLE) || (state == HOLD)) && slot_free;

  mult_operand_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data ({in_multiplicand, in_multiplier}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      mul_start        <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      out_valid        <= 1'b0;
      out_product      <= '0;
    end else begin
      mul_start <= 1'b0;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            mul_multiplicand <= fifo_head[PW-1:WIDTH];
            mul_multiplier   <= fifo_head[WIDTH-1:0];
            mul_start        <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: state <= BUSY;
        // The last shift lands on the edge leaving mul_done, so the product
        // is only sampled one cycle later, in SETTLE.
        BUSY: begin
          if (mul_done) state <= SETTLE;
        end
        SETTLE: state <= slot_free ? IDLE : HOLD;
        // Multiplier idles without reloading, so mul_product stays valid here.
        HOLD: begin
          if (slot_free) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (capture) begin
        out_product <= mul_product;
        out_valid   <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
